dmem_lsu: RTL

Parametrised data memory with a load/store unit for the MEM stage of the RISC-V pipeline. It accepts byte-addressed load/store requests through a valid/ready handshake and supports byte, halfword and word accesses with sign/zero extension. It has a configurable number of wait states, reports misaligned and faulting accesses, and initialises every word to its own index on reset.

---
 rtl/dmem_lsu.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Data memory with load/store unit for the MEM stage: valid/ready request port,
// B/H/W loads and stores with sign/zero extension, configurable wait states.
module dmem_lsu #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] result,
  output logic        misaligned,
  output logic        access_fault
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        p_wr_q;
  logic [2:0]  p_f3_q;
  logic [31:0] p_addr_q, p_wdata_q;
  logic [31:0] mem_q [DEPTH];
  logic        resp_valid_q, mis_q, fault_q;
  logic [31:0] result_q;

  logic          accept, commit, mis_c, fault_c, err_c;
  logic [AW-1:0] idx;
  logic [31:0]   word, load_v, wrep, merged_d;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [3:0]    wmask;

  assign req_ready = (state_q == IDLE) | (state_q == BUSY && cnt_q == '0);
  assign accept    = req_valid & req_ready & (mem_read | mem_write);
  assign commit    = (state_q == BUSY) && (cnt_q == '0);

  assign resp_valid   = resp_valid_q;
  assign result       = result_q;
  assign misaligned   = mis_q;
  assign access_fault = fault_q;

  always_comb begin
    idx     = p_addr_q[AW+1:2];
    word    = mem_q[idx];
    byte_v  = 8'(word >> {p_addr_q[1:0], 3'b000});
    half_v  = p_addr_q[1] ? word[31:16] : word[15:0];
    mis_c   = ((p_f3_q == 3'b001 || p_f3_q == 3'b101) && p_addr_q[0]) ||
              (p_f3_q == 3'b010 && p_addr_q[1:0] != 2'b00);
    fault_c = (p_addr_q[31:2] >= 30'(DEPTH));
    if (p_wr_q) begin
      if (p_f3_q[2] || p_f3_q == 3'b011) fault_c = 1'b1;
    end else begin
      if (p_f3_q == 3'b011 || p_f3_q == 3'b110 || p_f3_q == 3'b111) fault_c = 1'b1;
    end
    err_c = mis_c | fault_c;

    case (p_f3_q)
      3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_v = {{16{half_v[15]}}, half_v};
      3'b010:  load_v = word;
      3'b100:  load_v = {24'h0, byte_v};
      3'b101:  load_v = {16'h0, half_v};
      default: load_v = '0;
    endcase

    // Replicate store data across lanes so each enabled lane picks its own byte.
    case (p_f3_q)
      3'b000:  begin wmask = 4'b0001 << p_addr_q[1:0]; wrep = {4{p_wdata_q[7:0]}}; end
      3'b001:  begin wmask = p_addr_q[1] ? 4'b1100 : 4'b0011; wrep = {2{p_wdata_q[15:0]}}; end
      3'b010:  begin wmask = 4'b1111; wrep = p_wdata_q; end
      default: begin wmask = 4'b0000; wrep = p_wdata_q; end
    endcase
    merged_d = word;
    for (int unsigned k = 0; k < 4; k++) begin
      if (wmask[k]) merged_d[8*k +: 8] = wrep[8*k +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      p_wr_q       <= 1'b0;
      p_f3_q       <= '0;
      p_addr_q     <= '0;
      p_wdata_q    <= '0;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
      mis_q        <= 1'b0;
      fault_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= 32'(i);
    end else begin
      resp_valid_q <= commit;
      if (commit) begin
        result_q <= (err_c || p_wr_q) ? '0 : load_v;
        mis_q    <= mis_c;
        fault_q  <= fault_c;
        if (p_wr_q && !err_c) mem_q[idx] <= merged_d;
      end
      if (accept) begin
        state_q   <= BUSY;
        cnt_q     <= 4'(WAIT_STATES);
        p_wr_q    <= mem_write;
        p_f3_q    <= funct3;
        p_addr_q  <= address;
        p_wdata_q <= write_data;
      end else if (commit) begin
        state_q <= IDLE;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

endmodule
